or_arbiter: RTL and testbench

OR_ARBITER -- requirements
Module: or_arbiter

---
 rtl/or_arbiter.sv | 135 +++++++++++++
 tb/tb_or_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_arbiter.sv
// Shared bitwise-OR unit arbitrated among N_REQ requesters (IDLE -> CALC -> DONE).
// Define OR_ARB_FIXED_PRIO_EN for lowest-index-wins; round-robin otherwise.
module or_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  a_flat,
  input  logic [N_REQ*DATA_W-1:0]  b_flat,
  output logic [N_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]        res,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic                     busy,
  output logic [1:0]               dbg_state
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cur_id;
  logic [N_REQ-1:0]  onehot;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;

`ifdef OR_ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] last_winner;
  logic [ID_W-1:0] cand;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(N_REQ - 1)) ? '0 : v + ID_W'(1);
  endfunction

  // Scan starts just after the previous winner and wraps through index 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = wrap_inc(last_winner);
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = wrap_inc(cand);
    end
  end
`endif

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (found && winner == ID_W'(k)) begin
        a_sel     = a_flat[k*DATA_W +: DATA_W];
        b_sel     = b_flat[k*DATA_W +: DATA_W];
        onehot[k] = 1'b1;
      end
    end
  end

  // Result handshake: res/res_id are valid while res_valid=1; the transfer
  // happens on a rising edge with res_valid=1 and res_ack=1 (ack ignored otherwise).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
      cur_id    <= '0;
`ifndef OR_ARB_FIXED_PRIO_EN
      last_winner <= ID_W'(N_REQ - 1);
`endif
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= onehot;
            lat_a  <= a_sel;
            lat_b  <= b_sel;
            cur_id <= winner;
`ifndef OR_ARB_FIXED_PRIO_EN
            last_winner <= winner;
`endif
            state  <= CALC;
          end
        end
        CALC: begin
          res       <= lat_a | lat_b;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_or_arbiter.sv
// Randomized and directed bench for or_arbiter: a transaction-level model predicts
// grants and results; a monitor checks outputs each cycle against that model.
module tb_or_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = $clog2(N_REQ);
  localparam int EXP_W  = ID_W + DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] a_flat;
  logic [N_REQ*DATA_W-1:0] b_flat;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       res;
  logic [ID_W-1:0]         res_id;
  logic                    res_valid;
  logic                    res_ack;
  logic                    busy;
  logic [1:0]              dbg_state;

  // ---------------- clock / dut ----------------
  always #5 clk = ~clk;

  or_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .res(res), .res_id(res_id), .res_valid(res_valid),
    .res_ack(res_ack), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               cyc      = 0;
  int               gnt_cyc  = -10;
  bit               waiting  = 1'b0;
  int               m_last   = N_REQ - 1;
  logic [N_REQ-1:0] exp_gnt  = '0;
  bit               exp_valid = 1'b0;
  bit               exp_busy  = 1'b0;
  bit               rst_edge  = 1'b0;

  function automatic int pick(input logic [N_REQ-1:0] r, input int last);
    int p;
    p = -1;
`ifdef OR_ARB_FIXED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--) if (r[k]) p = k;
    if (last < 0) p = -1;
`else
    for (int k = N_REQ; k >= 1; k--) if (r[(last + k) % N_REQ]) p = (last + k) % N_REQ;
`endif
    return p;
  endfunction

  // Abstract timing: grant at edge g, result shown from edge g+1, consumed at the
  // first later edge with ack; a new request is accepted only when nothing is in flight.
  initial forever begin
    int w;
    @(posedge clk);
    cyc++;
    exp_gnt  = '0;
    rst_edge = rst;
    if (rst) begin
      waiting   = 1'b0;
      gnt_cyc   = -10;
      m_last    = N_REQ - 1;
      exp_valid = 1'b0;
      exp_q.delete();
    end else if (waiting) begin
      if (res_ack) begin
        waiting   = 1'b0;
        exp_valid = 1'b0;
      end
    end else if (gnt_cyc == cyc - 1) begin
      waiting   = 1'b1;
      exp_valid = 1'b1;
    end else if (req != '0) begin
      w          = pick(req, m_last);
      m_last     = w;
      gnt_cyc    = cyc;
      exp_gnt[w] = 1'b1;
      exp_q.push_back({ID_W'(w), a_flat[w*DATA_W +: DATA_W] | b_flat[w*DATA_W +: DATA_W]});
    end
    exp_busy = waiting || (gnt_cyc == cyc);
  end

  // ---------------- monitor / scoreboard ----------------
  bit                mon_en     = 1'b0;
  bit                prev_valid = 1'b0;
  logic [DATA_W-1:0] hold_res   = '0;
  logic [ID_W-1:0]   hold_id    = '0;
  int                gnt_hist[$];

  initial forever begin
    logic [EXP_W-1:0] e;
    @(negedge clk);
    if (mon_en) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("res_valid", 32'(res_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("dbg_state_legal", 32'(dbg_state != 2'd3), 32'd1);
      for (int k = 0; k < N_REQ; k++) if (gnt[k]) gnt_hist.push_back(k);
      if (rst_edge) begin
        hold_res = '0;
        hold_id  = '0;
      end
      if (res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL result_pop: res_valid rose with no transaction expected at %0t", $time);
        end else begin
          e        = exp_q.pop_front();
          hold_id  = e[EXP_W-1:DATA_W];
          hold_res = e[DATA_W-1:0];
        end
      end
      check("res", 32'(res), 32'(hold_res));
      check("res_id", 32'(res_id), 32'(hold_id));
      prev_valid = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    a_flat[i*DATA_W +: DATA_W] = a;
    b_flat[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) set_ops(i, DATA_W'($urandom), DATA_W'($urandom));
  endtask

  task automatic wait_gnt(output int id, input int budget);
    id = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (gnt != '0) begin
        for (int k = 0; k < N_REQ; k++) if (gnt[k]) id = k;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_gnt: no grant within %0d cycles", budget);
  endtask

  task automatic wait_valid(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (res_valid) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_valid: no result within %0d cycles", budget);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int id;
    int id2;
    int cnt;
    int exp_order[5];

    rst     = 1'b1;
    req     = '0;
    res_ack = 1'b0;
    a_flat  = '0;
    b_flat  = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_res", 32'(res), 32'd0);
    check("reset_res_id", 32'(res_id), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(2);

    // single requester 2, immediate ack
    gnt_hist.delete();
    set_ops(2, 8'h0F, 8'hF0);
    res_ack = 1'b1;
    req     = 4'b0100;
    tick();
    req = '0;
    wait_valid(5);
    check("single_res", 32'(res), 32'hFF);
    check("single_res_id", 32'(res_id), 32'd2);
    tick(4);
    check("single_gnt_count", 32'(gnt_hist.size()), 32'd1);

    // all requesting, immediate ack: grant order
    do_reset();
    gnt_hist.delete();
    rand_ops();
    res_ack = 1'b1;
    req     = 4'b1111;
    cnt     = 0;
    while (gnt_hist.size() < 5 && cnt < 40) begin
      tick();
      cnt++;
    end
    req = '0;
    tick(4);
`ifdef OR_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check("rr_gnt_count", 32'(gnt_hist.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_hist.size()) check("rr_order", 32'(gnt_hist[i]), 32'(exp_order[i]));

    // ack withheld in DONE for 5 cycles
    do_reset();
    gnt_hist.delete();
    set_ops(2, 8'h3C, 8'h81);
    res_ack = 1'b0;
    req     = 4'b0100;
    tick();
    req = '0;
    wait_valid(5);
    req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_res", 32'(res), 32'hBD);
    end
    check("hold_no_gnt", 32'(gnt_hist.size()), 32'd1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    wait_gnt(id, 5);
    check("after_ack_gnt", 32'(id), 32'd1);
    req     = '0;
    res_ack = 1'b1;
    tick(4);

    // reset while in CALC (no reset beforehand so res holds a stale value)
    rand_ops();
    req = 4'b1111;
    wait_gnt(id, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("calc_rst_valid", 32'(res_valid), 32'd0);
    check("calc_rst_busy", 32'(busy), 32'd0);
    check("calc_rst_res", 32'(res), 32'd0);
    check("calc_rst_gnt", 32'(gnt), 32'd0);
    wait_gnt(id2, 5);
    check("calc_rst_next_gnt", 32'(id2), 32'd0);
    req = '0;
    tick(4);

    // short pulse on req[1] while in DONE is never granted
    do_reset();
    gnt_hist.delete();
    rand_ops();
    res_ack = 1'b0;
    req     = 4'b0100;
    tick();
    req = '0;
    wait_valid(5);
    req = 4'b0010;
    tick();
    req = '0;
    tick(2);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    tick(6);
    check("pulse_gnt_count", 32'(gnt_hist.size()), 32'd1);
    if (gnt_hist.size() > 0) check("pulse_first_gnt", 32'(gnt_hist[0]), 32'd2);
    res_ack = 1'b1;
    tick(2);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      req     = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      res_ack = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 63) == 0);
      rand_ops();
      tick();
    end
    rst     = 1'b0;
    req     = '0;
    res_ack = 1'b1;
    tick(6);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
